// File: rtl/hilo_mul_pkg.sv
// Shared ALUOp codes, FSM state encoding and op classification for the HI/LO multiply unit.
package hilo_mul_pkg;

    localparam int OPW = 5;

    localparam logic [OPW-1:0] ALUOP_MULTU = 5'd26;
    localparam logic [OPW-1:0] ALUOP_MFLO  = 5'd27;
    localparam logic [OPW-1:0] ALUOP_MFHI  = 5'd28;
    localparam logic [OPW-1:0] ALUOP_MSUB  = 5'd29;
    localparam logic [OPW-1:0] ALUOP_MADD  = 5'd30;
    localparam logic [OPW-1:0] ALUOP_MUL   = 5'd31;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        ACC  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Codes that launch a multi-cycle multiply; mfhi/mflo are pure reads.
    function automatic logic is_mul_op(input logic [OPW-1:0] op);
        return (op == ALUOP_MULTU) || (op == ALUOP_MSUB) ||
               (op == ALUOP_MADD)  || (op == ALUOP_MUL);
    endfunction

    function automatic logic is_signed_op(input logic [OPW-1:0] op);
        return (op == ALUOP_MSUB) || (op == ALUOP_MADD) || (op == ALUOP_MUL);
    endfunction

endpackage

// File: rtl/hilo_mul_unit_shift_add_core.sv
// shift_add_core: radix-2 unsigned shift-add multiplier datapath, one multiplier bit per step.
// Latency: WIDTH steps (fewer under MUL_EARLY_EXIT_EN once the remaining multiplier bits are zero).
// Backpressure: none; advances only while step is high, load restarts it.
module shift_add_core #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 step,
    input  logic [WIDTH-1:0]     mcand_in,
    input  logic [WIDTH-1:0]     mplier_in,
    output logic [2*WIDTH-1:0]   prod,
    output logic                 last
);

    logic [2*WIDTH-1:0] mcand_q;
    logic [2*WIDTH-1:0] prod_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               cnt_last;
    logic               rest_zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            prod_q   <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else if (load) begin
            mcand_q  <= {{WIDTH{1'b0}}, mcand_in};
            prod_q   <= '0;
            mplier_q <= mplier_in;
            cnt_q    <= '0;
        end else if (step) begin
            if (mplier_q[0]) begin
                prod_q <= prod_q + mcand_q;
            end
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CNT_W'(1);
        end
    end

    assign cnt_last  = (cnt_q == CNT_W'(WIDTH - 1));
    // Bits still to be consumed after the one being added this step.
    assign rest_zero = (mplier_q[WIDTH-1:1] == '0);

`ifdef MUL_EARLY_EXIT_EN
    assign last = cnt_last || rest_zero;
`else
    assign last = cnt_last;
`endif

    assign prod = prod_q;

endmodule

// File: rtl/hilo_mul_unit.sv
// hilo_mul_unit: multu/madd/msub/mul engine owning HI/LO; Result muxes HI (mfhi), LO (mflo) or MulLo.
// Latency: Done pulses 34 cycles after an accepted Start (data-dependent if MUL_EARLY_EXIT_EN); mfhi/mflo are combinational.
// Backpressure: nothing is queued; Start and mthi/mtlo are dropped while Busy, the pipeline stalls on Busy.
module hilo_mul_unit
    import hilo_mul_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Start,
    input  logic [OPW-1:0]    ALUOp,
    input  logic [WIDTH-1:0]  A,
    input  logic [WIDTH-1:0]  B,
    input  logic              WriteHi,
    input  logic              WriteLo,
    output logic              Busy,
    output logic              Done,
    output logic [WIDTH-1:0]  HI,
    output logic [WIDTH-1:0]  LO,
    output logic [WIDTH-1:0]  Result
);

    state_t             state_q;
    state_t             state_d;
    logic [OPW-1:0]     op_q;
    logic               sign_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic [WIDTH-1:0]   mullo_q;

    logic               accept;
    logic               op_signed;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_signed;
    logic [2*WIDTH-1:0] hilo_cur;
    logic               core_last;
    logic               wr_window;

    assign accept    = (state_q == IDLE) && Start && is_mul_op(ALUOp);
    assign op_signed = is_signed_op(ALUOp);

    // Two's-complement negation of the most negative value yields the correct unsigned magnitude.
    assign mag_a = (op_signed && A[WIDTH-1]) ? -A : A;
    assign mag_b = (op_signed && B[WIDTH-1]) ? -B : B;

    shift_add_core #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_core (
        .clk       (Clk),
        .rst_n     (Rst),
        .load      (accept),
        .step      (state_q == CALC),
        .mcand_in  (mag_a),
        .mplier_in (mag_b),
        .prod      (prod),
        .last      (core_last)
    );

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        Busy    = 1'b0;
        Done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = CALC;
                end
            end
            CALC: begin
                Busy = 1'b1;
                if (core_last) begin
                    state_d = ACC;
                end
            end
            ACC: begin
                Busy    = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                Done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            op_q   <= '0;
            sign_q <= 1'b0;
        end else if (accept) begin
            op_q   <= ALUOp;
            sign_q <= op_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
        end
    end

    assign prod_signed = sign_q ? -prod : prod;
    assign hilo_cur    = {hi_q, lo_q};
    // An accepted Start in the same IDLE cycle takes priority over mthi/mtlo.
    assign wr_window   = ((state_q == IDLE) && !accept) || (state_q == DONE);

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            hi_q    <= '0;
            lo_q    <= '0;
            mullo_q <= '0;
        end else if (state_q == ACC) begin
            case (op_q)
                ALUOP_MULTU: {hi_q, lo_q} <= prod_signed;
                ALUOP_MADD:  {hi_q, lo_q} <= hilo_cur + prod_signed;
                ALUOP_MSUB:  {hi_q, lo_q} <= hilo_cur - prod_signed;
                ALUOP_MUL:   mullo_q      <= prod_signed[WIDTH-1:0];
                default: ;
            endcase
        end else if (wr_window) begin
            if (WriteHi) begin
                hi_q <= A;
            end
            if (WriteLo) begin
                lo_q <= A;
            end
        end
    end

    always_comb begin
        Result = mullo_q;
        if (ALUOp == ALUOP_MFHI) begin
            Result = hi_q;
        end else if (ALUOp == ALUOP_MFLO) begin
            Result = lo_q;
        end
    end

    assign HI = hi_q;
    assign LO = lo_q;

endmodule

// File: tb/tb_hilo_mul_unit.sv
// Scoreboard bench for hilo_mul_unit: directed cases plus random ops against a plain-arithmetic HI/LO model.
module tb_hilo_mul_unit;

    logic        Clk;
    logic        Rst;
    logic        Start;
    logic [4:0]  ALUOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        WriteHi;
    logic        WriteLo;
    logic        Busy;
    logic        Done;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] Result;

    hilo_mul_unit #(.WIDTH(32), .CNT_W(5)) dut (
        .Clk     (Clk),
        .Rst     (Rst),
        .Start   (Start),
        .ALUOp   (ALUOp),
        .A       (A),
        .B       (B),
        .WriteHi (WriteHi),
        .WriteLo (WriteLo),
        .Busy    (Busy),
        .Done    (Done),
        .HI      (HI),
        .LO      (LO),
        .Result  (Result)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] res;
        int          lat;
        int          start_cyc;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic [31:0] m_mul = '0;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: full-precision product, then the HI/LO update rule of the op.
    function automatic int model_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        logic [31:0] mb;
        longint      sa;
        longint      sbv;
        int          msb;
        if (op == 5'd26) begin
            p  = {32'b0, a} * {32'b0, b};
            mb = b;
        end else begin
            sa  = longint'($signed(a));
            sbv = longint'($signed(b));
            p   = 64'(sa * sbv);
            mb  = b[31] ? (32'd0 - b) : b;
        end
        case (op)
            5'd26: {m_hi, m_lo} = p;
            5'd30: {m_hi, m_lo} = {m_hi, m_lo} + p;
            5'd29: {m_hi, m_lo} = {m_hi, m_lo} - p;
            default: m_mul = p[31:0];
        endcase
        msb = 0;
        for (int i = 0; i < 32; i++) begin
            if (mb[i]) msb = i;
        end
`ifdef MUL_EARLY_EXIT_EN
        return msb + 1;
`else
        return (msb >= 0) ? 32 : 0;
`endif
    endfunction

    always @(negedge Clk) begin : monitor
        exp_t e;
        if (Rst && Done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got Done=1 expected no pending op (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                check("sb_hi", HI, e.hi);
                check("sb_lo", LO, e.lo);
                check("sb_mullo", Result, e.res);
                check("sb_latency", cyc - e.start_cyc, e.lat);
            end
        end
    end

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit inj, input bit whi);
        exp_t e;
        int   iters;
        int   bc;
        bit   got;
        @(negedge Clk);
        Start = 1'b1; ALUOp = op; A = a; B = b; WriteHi = whi; WriteLo = 1'b0;
        iters = model_op(op, a, b);
        e.hi = m_hi; e.lo = m_lo; e.res = m_mul; e.lat = iters + 2; e.start_cyc = cyc;
        sb.push_back(e);
        @(negedge Clk);
        Start = 1'b0; WriteHi = 1'b0; A = $urandom; B = $urandom;
        bc = 0;
        got = 0;
        for (int i = 0; i < 60; i++) begin
            if (Busy) bc++;
            if (Done) begin
                got = 1;
                break;
            end
            if (inj && i == 4) begin
                Start = 1'b1; WriteHi = 1'b1; ALUOp = 5'd26;
            end else begin
                Start = 1'b0; WriteHi = 1'b0; ALUOp = op;
            end
            @(negedge Clk);
        end
        check("done_seen", got, 1);
        check("busy_cycles", bc, iters + 1);
        @(negedge Clk);
        check("done_pulse", Done, 0);
    endtask

    task automatic wr(input bit whi, input bit wlo, input logic [31:0] v);
        @(negedge Clk);
        WriteHi = whi; WriteLo = wlo; A = v; ALUOp = 5'd0;
        @(negedge Clk);
        WriteHi = 1'b0; WriteLo = 1'b0;
        if (whi) m_hi = v;
        if (wlo) m_lo = v;
    endtask

    task automatic check_reads();
        ALUOp = 5'd28;
        #1 check("mfhi", Result, m_hi);
        ALUOp = 5'd27;
        #1 check("mflo", Result, m_lo);
    endtask

    initial begin
        int dc;
        Rst = 1'b0; Start = 1'b0; ALUOp = 5'd0; A = '0; B = '0; WriteHi = 1'b0; WriteLo = 1'b0;
        repeat (3) @(negedge Clk);
        check("rst_busy", Busy, 0);
        check("rst_done", Done, 0);
        check("rst_hi", HI, 0);
        check("rst_lo", LO, 0);
        check("rst_result", Result, 0);
        Rst = 1'b1;

        @(negedge Clk);
        Start = 1'b1; ALUOp = 5'd27; A = 32'h1234; B = 32'h5678;
        @(negedge Clk);
        Start = 1'b0;
        check("bad_op_ignored", Busy, 0);

        do_op(5'd26, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        check("multu_hi", HI, 32'hFFFF_FFFE);
        check("multu_lo", LO, 32'h0000_0001);

        wr(1'b1, 1'b1, 32'h0);
        wr(1'b0, 1'b1, 32'd5);
        do_op(5'd30, 32'hFFFF_FFFD, 32'd4, 0, 0);
        check("madd_hi", HI, 32'hFFFF_FFFF);
        ALUOp = 5'd27;
        #1 check("madd_mflo", Result, 32'hFFFF_FFF9);

        wr(1'b1, 1'b1, 32'h0);
        do_op(5'd29, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 0, 0);
        check("msub_hi", HI, 32'hFFFF_FFFF);
        check("msub_lo", LO, 32'hFFFF_FFFA);

        wr(1'b1, 1'b0, 32'h1234_5678);
        do_op(5'd31, 32'h0001_0000, 32'h0001_0000, 0, 0);
        ALUOp = 5'd31;
        #1 check("mul_result", Result, 32'h0);
        check("mul_hi_kept", HI, 32'h1234_5678);
        do_op(5'd31, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        ALUOp = 5'd31;
        #1 check("mul_minint", Result, 32'h8000_0000);

        // Reset in the middle of a multiply abandons it.
        @(negedge Clk);
        Start = 1'b1; ALUOp = 5'd26; A = $urandom; B = $urandom;
        @(negedge Clk);
        Start = 1'b0;
        repeat (9) @(negedge Clk);
        Rst = 1'b0;
        #1;
        check("abort_busy", Busy, 0);
        check("abort_hi", HI, 0);
        check("abort_lo", LO, 0);
        m_hi = '0; m_lo = '0; m_mul = '0;
        repeat (2) @(negedge Clk);
        Rst = 1'b1;
        dc = 0;
        repeat (40) begin
            @(negedge Clk);
            if (Done) dc++;
        end
        check("abort_no_done", dc, 0);
        do_op(5'd26, 32'd1000, 32'd3000, 0, 0);

        do_op(5'd26, 32'hDEAD_BEEF, 32'h0BAD_F00D, 1, 0);
        do_op(5'd30, 32'h0000_1234, 32'h8765_4321, 0, 1);
        check_reads();
        do_op(5'd26, 32'd7, 32'd1, 0, 0);
        check("early_lo", LO, 32'd7);

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 9) < 2) begin
                wr($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom);
            end else begin
                case ($urandom_range(0, 3))
                    0: do_op(5'd26, pick(), pick(), $urandom_range(0, 3) == 0, 0);
                    1: do_op(5'd29, pick(), pick(), 0, $urandom_range(0, 1) == 1);
                    2: do_op(5'd30, pick(), pick(), $urandom_range(0, 3) == 0, 0);
                    default: do_op(5'd31, pick(), pick(), 0, 0);
                endcase
            end
            check_reads();
        end

        repeat (3) @(negedge Clk);
        check("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hilo_mul_unit.md
Name: hilo_mul_unit

Overview:
- Multi-cycle multiply/accumulate unit that consumes the 5-bit ALUOp codes produced by the ALU control decoder.
- Executes multu, madd, msub and mul, and owns the HI/LO register pair.
- Sits beside the main ALU in EX. The pipeline stalls on Busy and reads results via the mfhi/mflo/mul codes.

Parameters:
- WIDTH, 32, operand width; HI, LO and Result are all WIDTH bits.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W >= WIDTH.

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- Rst  in  1  asynchronous, active-low reset.
- Start  in  1  request to launch the operation selected by ALUOp.
- ALUOp  in  5  operation code: 26 multu, 27 mflo, 28 mfhi, 29 msub, 30 madd, 31 mul.
- A  in  WIDTH  rs operand.
- B  in  WIDTH  rt operand.
- WriteHi  in  1  mthi strobe; HI <= A.
- WriteLo  in  1  mtlo strobe; LO <= A.
- Busy  out  1  high in CALC and ACC states.
- Done  out  1  one-cycle completion pulse.
- HI  out  WIDTH  HI register.
- LO  out  WIDTH  LO register.
- Result  out  WIDTH  combinational: HI if ALUOp==28; LO if ALUOp==27; otherwise MulLo register.

Behaviour:
- Reset (Rst low, asynchronous):
  - State=IDLE; HI, LO, MulLo, counter and internal product all 0.
  - Busy=0, Done=0.
  - Takes effect mid-operation: any operation in flight is abandoned and no Done is produced.
- States IDLE, CALC, ACC, DONE.
- IDLE:
  - Start=1 with ALUOp in {26,29,30,31} latches the op, |A|, |B| (A, B as-is for 26) and result sign (A[31]^B[31], signed ops only).
  - Clears the product and counter, then goes to CALC.
  - Start with any other ALUOp is ignored.
- CALC, radix-2 shift-add, one multiplier bit per cycle:
  - 64-bit unsigned product accumulated.
  - Counter increments; after WIDTH iterations go to ACC.
- ACC:
  - Negate the product if the sign is set.
  - Then apply the op:
    - multu: {HI,LO} = P.
    - madd: {HI,LO} = {HI,LO} + P, mod 2^64.
    - msub: {HI,LO} = {HI,LO} - P, mod 2^64.
    - mul: MulLo = P[31:0]; HI/LO unchanged.
  - Go to DONE.
- DONE: Done=1 for exactly one cycle; go to IDLE. A Start arriving in DONE is ignored.
- Latency: Start sampled at edge N → Busy high after N through N+33 → Done high between edges N+33 and N+34, at which point HI/LO/MulLo are already updated.
- Start while Busy or in DONE: ignored; the operands and op latched in IDLE are held.
- WriteHi/WriteLo:
  - Take effect at the edge only in IDLE or DONE; ignored while Busy.
  - Start and WriteHi/WriteLo in the same IDLE cycle: Start wins and the writes are dropped.
- mfhi/mflo: zero latency, combinational through Result; no Start needed and no state change.
- Signed edge case: A = 0x80000000 is handled via 32-bit unsigned magnitude 0x80000000 with no overflow.

Optional Feature:
- Macro MUL_EARLY_EXIT_EN.
- Defined: CALC exits to ACC as soon as the remaining unshifted multiplier bits are all zero. B=0 or 1 gives Done 3 cycles after Start; latency depends on the position of the highest set bit of |B|.
- Undefined: fixed WIDTH-iteration CALC; Done always 34 cycles after Start.

Decomposition:
- Package hilo_mul_pkg:
  - ALUOp constants ALUOP_MULTU=26, ALUOP_MFLO=27, ALUOP_MFHI=28, ALUOP_MSUB=29, ALUOP_MADD=30, ALUOP_MUL=31.
  - 2-bit state encoding IDLE=0, CALC=1, ACC=2, DONE=3.
- Sub-module shift_add_core: holds the product/multiplier shift registers and counter, plus the zero-detect used for early exit. The top level holds the FSM, sign logic, HI/LO/MulLo and the Result mux.

Test Plan:
- multu A=B=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001; Done exactly 34 cycles after Start, single-cycle pulse; Busy high 33 cycles.
- WriteLo A=5, then madd A=0xFFFFFFFD (-3), B=4 → HI=0xFFFFFFFF, LO=0xFFFFFFF9; Result with ALUOp=27 reads 0xFFFFFFF9.
- HI=LO=0, msub A=0xFFFFFFFE, B=0xFFFFFFFD → HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- mul A=B=0x00010000 with HI=0x12345678 → Result (ALUOp=31)=0x00000000; HI still 0x12345678. Then mul A=0x80000000, B=0xFFFFFFFF → MulLo=0x80000000.
- Start multu, assert Rst low at cycle 10 → Busy=0 immediately, HI=LO=0, no Done ever; next Start completes normally.
- Start and WriteHi pulsed during Busy → both ignored, result matches the original operands. Start+WriteHi together in IDLE → only the multiply executes.
- With MUL_EARLY_EXIT_EN: multu B=1, A=7 → LO=7, Done 3 cycles after Start.
